// File: rtl/audioport_pkg.sv
// Shared types and register map for the audio FIFO bank.
package audioport_pkg;

  // Playback state machine encoding, also visible in STATUS[1:0].
  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    PLAYING = 2'd1,
    STARVED = 2'd2
  } fifo_state_t;

  // Control register word offsets, counted from the first index after the FIFO data ports.
  localparam int REG_STATUS_OFS    = 0;
  localparam int REG_WATERMARK_OFS = 1;
  localparam int REG_UNDERRUN_OFS  = 2;
  localparam int REG_IRQ_OFS       = 3;

  // Absolute word index of a control register for a given channel count.
  function automatic logic [7:0] reg_index(input int channels, input int ofs);
    return 8'(channels + ofs);
  endfunction

endpackage

// File: rtl/audio_fifo_channel.sv
// One per-channel sample FIFO with level tracking and a synchronous flush.
module audio_fifo_channel #(
  parameter int DEPTH = 8,
  parameter int W     = 24
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clr,
  input  logic [W-1:0]                 wdata,
  output logic [W-1:0]                 head,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         empty,
  output logic                         full
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push_ok_s, pop_ok_s;

  assign empty     = (level_q == LW'(0));
  assign full      = (level_q == LW'(DEPTH));
  assign level     = level_q;
  assign head      = mem_q[rd_ptr_q];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Next storage, pointers and level; a flush overrides any push or pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok_s) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push_ok_s && !pop_ok_s) begin
        level_d = level_q + LW'(1);
      end else if (pop_ok_s && !push_ok_s) begin
        level_d = level_q - LW'(1);
      end else begin
        level_d = level_q;
      end
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/audio_fifo_bank.sv
// Multi-channel audio sample FIFO bank with APB3 access and a playback engine.
module audio_fifo_bank
  import audioport_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_WIDTH = 24
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [31:0]                    PADDR,
  input  logic [31:0]                    PWDATA,
  output logic [31:0]                    PRDATA,
  output logic                           PREADY,
  output logic                           PSLVERR,
  input  logic                           play_in,
  input  logic                           req_in,
  input  logic                           clr_in,
  output logic [CHANNELS*DATA_WIDTH-1:0] audio_out,
  output logic                           tick_out,
  output logic                           underrun_out,
  output logic                           irq_out
);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam logic [7:0]    IDX_STATUS = reg_index(CHANNELS, REG_STATUS_OFS);
  localparam logic [7:0]    IDX_WM     = reg_index(CHANNELS, REG_WATERMARK_OFS);
  localparam logic [7:0]    IDX_UCNT   = reg_index(CHANNELS, REG_UNDERRUN_OFS);
  localparam logic [7:0]    IDX_IRQ    = reg_index(CHANNELS, REG_IRQ_OFS);
  localparam logic [LW-1:0] WM_RESET   = LW'(FIFO_DEPTH / 2);

  fifo_state_t           state_q, state_d;
  logic                  req_q, req_d;
  logic                  irq_q, irq_d;
  logic [15:0]           ucnt_q, ucnt_d;
  logic [LW-1:0]         wm_q, wm_d;
  logic                  access_s, wr_s, rd_s, err_s, unused_s;
  logic [7:0]            idx_s;
  logic [31:0]           rdata_s;
  logic                  push_s  [CHANNELS];
  logic                  pop_s   [CHANNELS];
  logic                  empty_s [CHANNELS];
  logic                  full_s  [CHANNELS];
  logic [DATA_WIDTH-1:0] head_s  [CHANNELS];
  logic [LW-1:0]         level_s [CHANNELS];
  logic                  all_nonempty_s, all_above_wm_s, min_le_wm_s, tick_s, underrun_s;

  assign access_s     = PSEL & PENABLE;
  assign wr_s         = access_s & PWRITE;
  assign rd_s         = access_s & ~PWRITE;
  assign idx_s        = PADDR[9:2];
  assign unused_s     = ^{PADDR, PWDATA};
  assign PREADY       = 1'b1;
  assign tick_out     = tick_s;
  assign underrun_out = underrun_s;
  assign irq_out      = irq_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    audio_fifo_channel #(.DEPTH(FIFO_DEPTH), .W(DATA_WIDTH)) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s[c]),
      .pop   (pop_s[c]),
      .clr   (clr_in),
      .wdata (PWDATA[DATA_WIDTH-1:0]),
      .head  (head_s[c]),
      .level (level_s[c]),
      .empty (empty_s[c]),
      .full  (full_s[c])
    );
  end

  // Bank-wide level summaries used by playback and the interrupt.
  always_comb begin
    all_nonempty_s = 1'b1;
    all_above_wm_s = 1'b1;
    min_le_wm_s    = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      all_nonempty_s = all_nonempty_s & ~empty_s[c];
      all_above_wm_s = all_above_wm_s & (level_s[c] > wm_q);
      min_le_wm_s    = min_le_wm_s | (level_s[c] <= wm_q);
    end
  end

  // Playback FSM next state plus the tick/underrun strobes it decides.
  always_comb begin
    state_d    = state_q;
    tick_s     = 1'b0;
    underrun_s = 1'b0;
    if (!play_in) begin
      state_d = STOPPED;
    end else begin
      case (state_q)
        STOPPED: state_d = PLAYING;
        PLAYING: begin
          if (req_q && all_nonempty_s) begin
            tick_s = 1'b1;
          end else if (req_q) begin
            underrun_s = 1'b1;
            state_d    = STARVED;
          end else begin
            state_d = PLAYING;
          end
        end
        STARVED: begin
          if (all_above_wm_s) begin
            state_d = PLAYING;
          end else begin
            state_d = STARVED;
          end
        end
        default: state_d = STOPPED;
      endcase
    end
  end

  // Per-channel push/pop strobes and the head samples presented to the output stage.
  // APB pops need play_in=0 and playback pops need play_in=1, so the two never collide.
  always_comb begin
    push_s    = '{default: 1'b0};
    pop_s     = '{default: 1'b0};
    audio_out = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      push_s[c] = wr_s & (idx_s == 8'(c)) & ~full_s[c];
      pop_s[c]  = tick_s | (rd_s & (idx_s == 8'(c)) & ~play_in & ~empty_s[c]);
      if (state_q == PLAYING && !empty_s[c]) begin
        audio_out[c*DATA_WIDTH +: DATA_WIDTH] = head_s[c];
      end else begin
        audio_out[c*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
  end

  // Control register updates, request capture and sticky interrupt.
  always_comb begin
    req_d  = req_in & (state_q != STOPPED);
    wm_d   = wm_q;
    ucnt_d = ucnt_q;
    irq_d  = irq_q;
    if (wr_s && idx_s == IDX_WM) begin
      wm_d = PWDATA[LW-1:0];
    end else begin
      wm_d = wm_q;
    end
    if (wr_s && idx_s == IDX_UCNT) begin
      ucnt_d = 16'd0;
    end else if (underrun_s && ucnt_q != 16'hFFFF) begin
      ucnt_d = ucnt_q + 16'd1;
    end else begin
      ucnt_d = ucnt_q;
    end
    if (state_q != STOPPED && min_le_wm_s) begin
      irq_d = 1'b1;
    end else if (wr_s && idx_s == IDX_IRQ && PWDATA[0]) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  // APB read mux and error response, driven only in the access phase.
  always_comb begin
    rdata_s = 32'd0;
    err_s   = 1'b0;
    case (idx_s)
      IDX_STATUS: begin
        rdata_s[1:0] = state_q;
        for (int c = 0; c < CHANNELS; c++) begin
          rdata_s[8+c]  = empty_s[c];
          rdata_s[16+c] = full_s[c];
        end
        rdata_s[24] = irq_q;
      end
      IDX_WM:   rdata_s = 32'(wm_q);
      IDX_UCNT: rdata_s = {16'd0, ucnt_q};
      IDX_IRQ:  rdata_s = {31'd0, irq_q};
      default: begin
        for (int c = 0; c < CHANNELS; c++) begin
          if (idx_s == 8'(c)) begin
            rdata_s = empty_s[c] ? 32'd0 : 32'(head_s[c]);
            err_s   = PWRITE ? full_s[c] : empty_s[c];
          end else begin
            err_s = err_s;
          end
        end
      end
    endcase
    PRDATA  = rd_s ? rdata_s : 32'd0;
    PSLVERR = access_s & err_s;
  end

  // Control and playback state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STOPPED;
      req_q   <= 1'b0;
      irq_q   <= 1'b0;
      ucnt_q  <= 16'd0;
      wm_q    <= WM_RESET;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      irq_q   <= irq_d;
      ucnt_q  <= ucnt_d;
      wm_q    <= wm_d;
    end
  end

endmodule

// File: tb/tb_audio_fifo_bank.sv
// Self-checking bench for audio_fifo_bank: scenario tasks against a queue-based reference model.
module tb_audio_fifo_bank;
  import audioport_pkg::*;

  localparam int CH  = 2;
  localparam int DEP = 8;
  localparam int DW  = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = 32'd0, PWDATA = 32'd0;
  logic [31:0] PRDATA;
  logic PREADY, PSLVERR;
  logic play_in = 1'b0, req_in = 1'b0, clr_in = 1'b0;
  logic [CH*DW-1:0] audio_out;
  logic tick_out, underrun_out, irq_out;

  always #5 clk = ~clk;

  audio_fifo_bank #(.CHANNELS(CH), .FIFO_DEPTH(DEP), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .play_in(play_in), .req_in(req_in), .clr_in(clr_in), .audio_out(audio_out),
    .tick_out(tick_out), .underrun_out(underrun_out), .irq_out(irq_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: sample queues plus architectural register values.
  logic [DW-1:0] mq [CH][$];
  fifo_state_t   exp_state = STOPPED;
  logic          exp_irq   = 1'b0;
  int            exp_ucnt  = 0;
  int            exp_wm    = DEP / 2;

  function automatic logic [31:0] exp_status();
    logic [31:0] s = 32'd0;
    s[1:0] = exp_state;
    for (int c = 0; c < CH; c++) begin
      s[8+c]  = (mq[c].size() == 0);
      s[16+c] = (mq[c].size() == DEP);
    end
    s[24] = exp_irq;
    return s;
  endfunction

  function automatic logic [CH*DW-1:0] exp_heads();
    logic [CH*DW-1:0] a = '0;
    for (int c = 0; c < CH; c++) begin
      if (mq[c].size() > 0) a[c*DW +: DW] = mq[c][0];
    end
    return a;
  endfunction

  task automatic apb_write(input int idx, input logic [31:0] data, output logic err);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'(idx) << 2; PWDATA = data;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(negedge clk);
    err = PSLVERR;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input int idx, output logic [31:0] data, output logic err);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'(idx) << 2;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(negedge clk);
    data = PRDATA; err = PSLVERR;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic pulse_req(output logic t, output logic u, output logic [CH*DW-1:0] a);
    @(posedge clk); #1 req_in = 1'b1;
    @(posedge clk); #1 req_in = 1'b0;
    @(negedge clk);
    t = tick_out; u = underrun_out; a = audio_out;
    @(posedge clk); #1;
  endtask

  task automatic set_play(input logic p);
    @(posedge clk); #1 play_in = p;
    @(posedge clk); @(posedge clk); #1;
    exp_state = p ? PLAYING : STOPPED;
  endtask

  task automatic push_random(input int c, input int n);
    logic e;
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = DW'($urandom);
      apb_write(c, 32'(d), e);
      n_checks++;
      if (e !== 1'b0) begin n_fail++; $display("FAIL push_err ch%0d got=%b want=0", c, e); end
      mq[c].push_back(d);
    end
  endtask

  task automatic drain_check(input int c);
    logic [31:0] d;
    logic e;
    int n = mq[c].size();
    for (int i = 0; i <= n; i++) begin
      logic [31:0] wd = (mq[c].size() > 0) ? 32'(mq[c][0]) : 32'd0;
      logic we = (mq[c].size() == 0);
      apb_read(c, d, e);
      n_checks++;
      if (d !== wd || e !== we) begin
        n_fail++; $display("FAIL drain ch%0d[%0d] got=%h/%b want=%h/%b", c, i, d, e, wd, we);
      end
      if (mq[c].size() > 0) void'(mq[c].pop_front());
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic e;
    @(negedge clk);
    n_checks++;
    if ({audio_out, tick_out, underrun_out, irq_out, PSLVERR, PRDATA} !== '0 || PREADY !== 1'b1) begin
      n_fail++; $display("FAIL reset_outputs got audio=%h prdata=%h pready=%b", audio_out, PRDATA, PREADY);
    end
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    apb_read(CH, d, e);
    n_checks++;
    if (d !== exp_status()) begin n_fail++; $display("FAIL reset_status got=%h want=%h", d, exp_status()); end
    apb_read(CH + 1, d, e);
    n_checks++;
    if (d !== 32'(exp_wm)) begin n_fail++; $display("FAIL reset_wm got=%h want=%h", d, exp_wm); end
    apb_read(CH + 2, d, e);
    n_checks++;
    if (d !== 32'd0) begin n_fail++; $display("FAIL reset_ucnt got=%h want=0", d); end
    apb_read(20, d, e);
    n_checks++;
    if (d !== 32'd0 || e !== 1'b0) begin n_fail++; $display("FAIL unmapped got=%h/%b want=0/0", d, e); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic e;
    push_random(0, DEP);
    apb_write(0, $urandom, e);
    n_checks++;
    if (e !== 1'b1) begin n_fail++; $display("FAIL overflow_err got=%b want=1", e); end
    apb_read(CH, d, e);
    n_checks++;
    if (d !== exp_status() || d[16] !== 1'b1) begin n_fail++; $display("FAIL full_status got=%h want=%h", d, exp_status()); end
    drain_check(0);
  endtask

  task automatic test_random_apb();
    logic [31:0] d;
    logic e;
    for (int i = 0; i < 40; i++) begin
      int c = $urandom_range(0, CH - 1);
      if ($urandom_range(0, 2) != 0) begin
        logic [DW-1:0] v = DW'($urandom);
        logic we = (mq[c].size() == DEP);
        apb_write(c, {8'hA5, v}, e);
        n_checks++;
        if (e !== we) begin n_fail++; $display("FAIL rnd_wr ch%0d got=%b want=%b", c, e, we); end
        if (!we) mq[c].push_back(v);
      end else begin
        logic [31:0] wd = (mq[c].size() > 0) ? 32'(mq[c][0]) : 32'd0;
        logic we = (mq[c].size() == 0);
        apb_read(c, d, e);
        n_checks++;
        if (d !== wd || e !== we) begin n_fail++; $display("FAIL rnd_rd ch%0d got=%h/%b want=%h/%b", c, d, e, wd, we); end
        if (!we) void'(mq[c].pop_front());
      end
    end
    @(posedge clk); #1 clr_in = 1'b1;
    @(posedge clk); #1 clr_in = 1'b0;
    for (int c = 0; c < CH; c++) mq[c].delete();
    apb_read(CH, d, e);
    n_checks++;
    if (d !== exp_status()) begin n_fail++; $display("FAIL clr_status got=%h want=%h", d, exp_status()); end
  endtask

  task automatic test_playback();
    logic t, u;
    logic [CH*DW-1:0] a, wa;
    logic [31:0] d;
    logic e;
    for (int c = 0; c < CH; c++) push_random(c, 3);
    set_play(1'b1);
    exp_irq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic wt = (mq[0].size() > 0 && mq[1].size() > 0);
      wa = exp_heads();
      pulse_req(t, u, a);
      n_checks++;
      if (t !== wt || u !== !wt || a !== wa) begin
        n_fail++; $display("FAIL play_req%0d got t=%b u=%b a=%h want t=%b u=%b a=%h", i, t, u, a, wt, !wt, wa);
      end
      if (wt) begin
        for (int c = 0; c < CH; c++) void'(mq[c].pop_front());
      end else begin
        exp_ucnt++; exp_state = STARVED;
      end
    end
    apb_read(CH + 2, d, e);
    n_checks++;
    if (d !== 32'(exp_ucnt)) begin n_fail++; $display("FAIL ucnt got=%h want=%h", d, exp_ucnt); end
    apb_read(CH, d, e);
    n_checks++;
    if (d !== exp_status()) begin n_fail++; $display("FAIL starved_status got=%h want=%h", d, exp_status()); end
  endtask

  task automatic test_starved_refill();
    logic t, u;
    logic [CH*DW-1:0] a;
    logic [31:0] d;
    logic e;
    apb_write(CH + 1, 32'd4, e);
    exp_wm = 4;
    for (int c = 0; c < CH; c++) push_random(c, 4);
    apb_read(CH, d, e);
    n_checks++;
    if (d !== exp_status()) begin n_fail++; $display("FAIL at_wm_status got=%h want=%h", d, exp_status()); end
    pulse_req(t, u, a);
    n_checks++;
    if (t !== 1'b0 || u !== 1'b0 || a !== '0) begin
      n_fail++; $display("FAIL starved_req got t=%b u=%b a=%h want 0 0 0", t, u, a);
    end
    for (int c = 0; c < CH; c++) push_random(c, 1);
    @(posedge clk); @(posedge clk); #1;
    exp_state = PLAYING;
    apb_read(CH, d, e);
    n_checks++;
    if (d !== exp_status()) begin n_fail++; $display("FAIL resume_status got=%h want=%h", d, exp_status()); end
  endtask

  task automatic test_irq();
    logic t, u;
    logic [CH*DW-1:0] a, wa;
    logic e;
    apb_write(CH + 3, 32'd1, e);
    exp_irq = 1'b0;
    @(negedge clk);
    n_checks++;
    if (irq_out !== exp_irq) begin n_fail++; $display("FAIL irq_clear got=%b want=0", irq_out); end
    wa = exp_heads();
    pulse_req(t, u, a);
    for (int c = 0; c < CH; c++) void'(mq[c].pop_front());
    n_checks++;
    if (t !== 1'b1 || a !== wa) begin n_fail++; $display("FAIL irq_tick got t=%b a=%h want 1 %h", t, a, wa); end
    exp_irq = 1'b1;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (irq_out !== exp_irq) begin n_fail++; $display("FAIL irq_set got=%b want=1", irq_out); end
    apb_write(CH + 3, 32'd1, e);
    @(negedge clk);
    n_checks++;
    if (irq_out !== exp_irq) begin n_fail++; $display("FAIL irq_set_wins got=%b want=1", irq_out); end
  endtask

  task automatic test_push_pop_same();
    logic t, u, e;
    logic [CH*DW-1:0] a, wa;
    logic [DW-1:0] v;
    wa = exp_heads();
    pulse_req(t, u, a);
    for (int c = 0; c < CH; c++) void'(mq[c].pop_front());
    n_checks++;
    if (t !== 1'b1 || a !== wa) begin n_fail++; $display("FAIL pre_tick got t=%b a=%h want 1 %h", t, a, wa); end
    v = DW'($urandom);
    wa = exp_heads();
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'd1 << 2; PWDATA = 32'(v); req_in = 1'b1;
    @(posedge clk); #1;
    PENABLE = 1'b1; req_in = 1'b0;
    @(negedge clk);
    t = tick_out; e = PSLVERR; a = audio_out;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    n_checks++;
    if (t !== 1'b1 || e !== 1'b0 || a !== wa) begin
      n_fail++; $display("FAIL same_cycle got t=%b err=%b a=%h want 1 0 %h", t, e, a, wa);
    end
    for (int c = 0; c < CH; c++) void'(mq[c].pop_front());
    mq[1].push_back(v);
    set_play(1'b0);
    drain_check(1);
    drain_check(0);
  endtask

  task automatic test_clear();
    logic t, u, e;
    logic [CH*DW-1:0] a;
    logic [31:0] d;
    for (int c = 0; c < CH; c++) push_random(c, 3);
    apb_write(CH + 1, 32'd6, e);
    exp_wm = 6;
    set_play(1'b1);
    @(posedge clk); #1 clr_in = 1'b1;
    @(posedge clk); #1 clr_in = 1'b0;
    for (int c = 0; c < CH; c++) mq[c].delete();
    pulse_req(t, u, a);
    exp_ucnt++; exp_state = STARVED;
    n_checks++;
    if (t !== 1'b0 || u !== 1'b1) begin n_fail++; $display("FAIL clr_underrun got t=%b u=%b want 0 1", t, u); end
    apb_read(CH, d, e);
    n_checks++;
    if (d !== exp_status()) begin n_fail++; $display("FAIL clr_status2 got=%h want=%h", d, exp_status()); end
    apb_read(CH + 1, d, e);
    n_checks++;
    if (d !== 32'(exp_wm)) begin n_fail++; $display("FAIL clr_wm got=%h want=%h", d, exp_wm); end
    apb_read(CH + 2, d, e);
    n_checks++;
    if (d !== 32'(exp_ucnt)) begin n_fail++; $display("FAIL clr_ucnt got=%h want=%h", d, exp_ucnt); end
    apb_write(CH + 2, $urandom, e);
    exp_ucnt = 0;
    apb_read(CH + 2, d, e);
    n_checks++;
    if (d !== 32'(exp_ucnt)) begin n_fail++; $display("FAIL ucnt_wclr got=%h want=0", d); end
    set_play(1'b0);
  endtask

  task automatic test_reset_mid();
    logic t, u, e;
    logic [CH*DW-1:0] a, wa;
    logic [31:0] d;
    for (int c = 0; c < CH; c++) push_random(c, DEP);
    set_play(1'b1);
    wa = exp_heads();
    pulse_req(t, u, a);
    n_checks++;
    if (t !== 1'b1 || a !== wa) begin n_fail++; $display("FAIL full_tick got t=%b a=%h want 1 %h", t, a, wa); end
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({audio_out, tick_out, underrun_out, irq_out, PSLVERR, PRDATA} !== '0 || PREADY !== 1'b1) begin
      n_fail++; $display("FAIL midreset_outputs got audio=%h tick=%b irq=%b pready=%b", audio_out, tick_out, irq_out, PREADY);
    end
    play_in = 1'b0;
    for (int c = 0; c < CH; c++) mq[c].delete();
    exp_state = STOPPED; exp_irq = 1'b0; exp_ucnt = 0; exp_wm = DEP / 2;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    apb_read(CH, d, e);
    n_checks++;
    if (d !== exp_status()) begin n_fail++; $display("FAIL midreset_status got=%h want=%h", d, exp_status()); end
    apb_read(CH + 1, d, e);
    n_checks++;
    if (d !== 32'(exp_wm)) begin n_fail++; $display("FAIL midreset_wm got=%h want=%h", d, exp_wm); end
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_random_apb();
    test_playback();
    test_starved_refill();
    test_irq();
    test_push_pop_same();
    test_clear();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_fifo_bank.md
AUDIO_FIFO_BANK -- requirements
Module: audio_fifo_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of audio channels, legal range 1..8.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, entries per channel, power of two, legal range 2..256.
REQ-003 SHALL have parameter DATA_WIDTH, default 24, sample width, legal range 8..32.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports PSEL, PENABLE, PWRITE (input, 1), PADDR and PWDATA (input, 32): APB3 slave request.
REQ-007 SHALL have ports PRDATA (output, 32), PREADY (output, 1, tied 1) and PSLVERR (output, 1): APB3 response.
REQ-008 SHALL have port play_in, input, 1, playback enable.
REQ-009 SHALL have port req_in, input, 1, sample request from the output stage.
REQ-010 SHALL have port clr_in, input, 1, synchronous flush of all FIFOs.
REQ-011 SHALL have port audio_out, output, CHANNELS*DATA_WIDTH, head sample per channel, channel 0 in the LSBs.
REQ-012 SHALL have ports tick_out, underrun_out and irq_out, each output, 1.

Function
REQ-013 SHALL decode the word index as PADDR[9:2]: 0..CHANNELS-1 FIFO data, CHANNELS STATUS, CHANNELS+1 WATERMARK, CHANNELS+2 UNDERRUN_CNT, CHANNELS+3 IRQ; other indices read 0 and ignore writes.
REQ-014 SHALL act only in the access phase (PSEL&PENABLE); PSLVERR is 0 outside it.
REQ-015 SHALL push PWDATA[DATA_WIDTH-1:0] on a write to FIFO c when c is not full; a write to a full FIFO is dropped with PSLVERR=1.
REQ-016 SHALL return the zero-extended head on a read of FIFO c and pop it only when play_in=0 and c is non-empty; a read of an empty FIFO returns 0 with PSLVERR=1.
REQ-017 SHALL keep a per-channel level 0..FIFO_DEPTH; a push and a pop in the same cycle leave the level unchanged and both take effect.
REQ-018 SHALL implement playback FSM STOPPED, PLAYING, STARVED, reset STOPPED; play_in=0 forces STOPPED from any state.
REQ-019 SHALL register req_in into req_r each cycle, forced 0 in STOPPED.
REQ-020 SHALL transition STOPPED->PLAYING when play_in=1.
REQ-021 SHALL, in PLAYING with req_r=1: if every channel is non-empty, pop all channels together and assert tick_out that cycle; otherwise pop nothing, pulse underrun_out, increment UNDERRUN_CNT and enter STARVED.
REQ-022 SHALL leave STARVED for PLAYING when every channel level exceeds WATERMARK; no pops occur and tick_out stays 0 while STARVED.
REQ-023 SHALL drive audio_out slice c with the head of FIFO c in PLAYING when non-empty, and 0 otherwise.
REQ-024 SHALL saturate UNDERRUN_CNT (16 bits) at 0xFFFF; any write to it clears it to 0.
REQ-025 SHALL hold WATERMARK at $clog2(FIFO_DEPTH+1) bits, written from PWDATA LSBs and reset to FIFO_DEPTH/2.
REQ-026 SHALL set sticky irq_r when state is not STOPPED and minimum channel level <= WATERMARK; writing 1 to IRQ bit0 clears it; set wins over a same-cycle clear; irq_out=irq_r.
REQ-027 SHALL read STATUS as [1:0] FSM state, [8+c] empty of c, [16+c] full of c, [24] irq_r, others 0.
REQ-028 SHALL have clr_in reset all pointers and levels with priority over same-cycle pushes and pops; UNDERRUN_CNT, WATERMARK and FSM are unaffected; clr_in while PLAYING yields an underrun on the next req_r.

Reset
REQ-029 SHALL, while rst_n=0, clear FIFOs, levels, req_r, irq_r and UNDERRUN_CNT, set FSM STOPPED and WATERMARK FIFO_DEPTH/2; all outputs 0 except PREADY=1.
REQ-030 SHALL abandon any in-progress transfer or playback on reset with no residual pop or push.

Structure
REQ-031 SHALL place fifo_state_t (STOPPED, PLAYING, STARVED) and register offset constants in audioport_pkg.
REQ-032 SHALL use one sub-module audio_fifo_channel (push, pop, clr, head, level, empty, full), instantiated CHANNELS times by generate.

Verification (defaults CHANNELS=2, FIFO_DEPTH=8, DATA_WIDTH=24)
REQ-033 SHALL cover: push 9 writes to FIFO 0 -> first 8 accepted, 9th PSLVERR=1, STATUS[16]=1.
REQ-034 SHALL cover: 3 samples per channel, play_in=1, req_in pulsed 3 times -> 3 tick_out, audio_out in write order, 4th req -> underrun_out, UNDERRUN_CNT=1, STATUS[1:0]=STARVED.
REQ-035 SHALL cover: in STARVED with WATERMARK=4, refill to 4 each -> stays STARVED; 5th sample each -> PLAYING.
REQ-036 SHALL cover: playing with levels 5, WATERMARK=4, one tick -> irq_out=1; IRQ write while level stays 4 -> irq_out remains 1.
REQ-037 SHALL cover: same-cycle APB push and playback pop on channel 1 at level 3 -> level stays 3, new sample at tail.
REQ-038 SHALL cover: rst_n low mid-playback with full FIFOs -> all outputs 0, STATUS shows STOPPED and empty bits set.
